// File: rtl/json_cmd_rx_pkg.sv
// Shared types and constants for the json_cmd_rx wheel-command parser.
package json_cmd_rx_pkg;

  // state | meaning: IDLE hunt '{' | HDR "T":1,"L": | LNUM left number
  //                  MID ,"R": | RNUM right number | TAIL '}' then LF
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_LNUM,
    ST_MID,
    ST_RNUM,
    ST_TAIL
  } state_e;

  localparam logic [3:0] MOVE_FWD     = 4'd0;
  localparam logic [3:0] MOVE_TURN_L  = 4'd1;
  localparam logic [3:0] MOVE_TURN_R  = 4'd2;
  localparam logic [3:0] MOVE_REV     = 4'd3;
  localparam logic [3:0] MOVE_SPIN_L  = 4'd4;
  localparam logic [3:0] MOVE_SPIN_R  = 4'd5;
  localparam logic [3:0] MOVE_BACK_L  = 4'd6;
  localparam logic [3:0] MOVE_BACK_R  = 4'd7;
  localparam logic [3:0] MOVE_STOP    = 4'b1000;
  localparam logic [3:0] MOVE_UNKNOWN = 4'b1111;

  localparam logic [7:0] ASC_LBRACE = 8'h7B;
  localparam logic [7:0] ASC_RBRACE = 8'h7D;
  localparam logic [7:0] ASC_MINUS  = 8'h2D;
  localparam logic [7:0] ASC_DOT    = 8'h2E;
  localparam logic [7:0] ASC_COLON  = 8'h3A;
  localparam logic [7:0] ASC_COMMA  = 8'h2C;
  localparam logic [7:0] ASC_LF     = 8'h0A;
  localparam logic [7:0] ASC_QUOTE  = 8'h22;
  localparam logic [7:0] ASC_ZERO   = 8'h30;
  localparam logic [7:0] ASC_ONE    = 8'h31;
  localparam logic [7:0] ASC_NINE   = 8'h39;
  localparam logic [7:0] ASC_T      = 8'h54;
  localparam logic [7:0] ASC_L      = 8'h4C;
  localparam logic [7:0] ASC_R      = 8'h52;

  localparam logic [3:0] HDR_LAST = 4'd9;
  localparam logic [3:0] MID_LAST = 4'd4;

  function automatic logic [7:0] hdr_byte(input logic [3:0] idx);
    case (idx)
      4'd0:    return ASC_QUOTE;
      4'd1:    return ASC_T;
      4'd2:    return ASC_QUOTE;
      4'd3:    return ASC_COLON;
      4'd4:    return ASC_ONE;
      4'd5:    return ASC_COMMA;
      4'd6:    return ASC_QUOTE;
      4'd7:    return ASC_L;
      4'd8:    return ASC_QUOTE;
      default: return ASC_COLON;
    endcase
  endfunction

  function automatic logic [7:0] mid_byte(input logic [3:0] idx);
    case (idx)
      4'd0:    return ASC_COMMA;
      4'd1:    return ASC_QUOTE;
      4'd2:    return ASC_R;
      4'd3:    return ASC_QUOTE;
      default: return ASC_COLON;
    endcase
  endfunction

endpackage

// File: rtl/json_cmd_rx_cmd_decode.sv
// Maps the accepted signed wheel magnitudes onto a motion code.
module cmd_decode
  import json_cmd_rx_pkg::*;
(
  input  logic [3:0] l_mag_i,
  input  logic       l_neg_i,
  input  logic [3:0] r_mag_i,
  input  logic       r_neg_i,
  output logic [3:0] move_cmd_o
);

  logic l_zero;
  logic r_zero;
  logic same_mag;

  assign l_zero   = (l_mag_i == 4'd0);
  assign r_zero   = (r_mag_i == 4'd0);
  assign same_mag = (l_mag_i == r_mag_i);

  always_comb begin
    move_cmd_o = MOVE_UNKNOWN;
    if (l_zero && r_zero) begin
      move_cmd_o = MOVE_STOP;
    end else if (l_zero) begin
      move_cmd_o = r_neg_i ? MOVE_BACK_L : MOVE_TURN_L;
    end else if (r_zero) begin
      move_cmd_o = l_neg_i ? MOVE_BACK_R : MOVE_TURN_R;
    end else if (same_mag) begin
      case ({l_neg_i, r_neg_i})
        2'b00:   move_cmd_o = MOVE_FWD;
        2'b11:   move_cmd_o = MOVE_REV;
        2'b10:   move_cmd_o = MOVE_SPIN_L;
        default: move_cmd_o = MOVE_SPIN_R;
      endcase
    end
  end

endmodule

// File: rtl/json_cmd_rx.sv
// Byte-stream parser for {"T":1,"L":<n>,"R":<n>}\n wheel commands.
// Define CMD_TIMEOUT_EN to abort frames stalled for TIMEOUT_CLKS clocks.
module json_cmd_rx
  import json_cmd_rx_pkg::*;
#(
  parameter int unsigned TIMEOUT_CLKS = 8680
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [3:0] left_speed,
  output logic [3:0] right_speed,
  output logic       left_neg,
  output logic       right_neg,
  output logic [3:0] move_cmd,
  output logic [3:0] speed_level,
  output logic       cmd_valid,
  output logic       frame_err
);

  if (TIMEOUT_CLKS < 1) begin : g_bad_timeout
    $error("TIMEOUT_CLKS must be at least 1");
  end

  state_e     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic       sign_q, sign_d;
  logic [3:0] pl_mag_q, pl_mag_d, pr_mag_q, pr_mag_d;
  logic       pl_neg_q, pl_neg_d, pr_neg_q, pr_neg_d;
  logic [3:0] l_mag_q, l_mag_d, r_mag_q, r_mag_d;
  logic       l_neg_q, l_neg_d, r_neg_q, r_neg_d;
  logic       cmd_valid_q, cmd_valid_d;
  logic       frame_err_q, frame_err_d;
  logic       is_digit;
  logic       abort;
  logic       timeout_hit;

  assign is_digit = (rx_data >= ASC_ZERO) && (rx_data <= ASC_NINE);

`ifdef CMD_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CLKS - 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Down-counter reloads on every byte; terminal count while mid-frame aborts.
  always_comb begin
    tmo_d = tmo_q;
    if (rx_valid || state_q == ST_IDLE) begin
      tmo_d = TMO_LOAD;
    end else if (tmo_q != '0) begin
      tmo_d = tmo_q - TMO_W'(1);
    end
  end

  assign timeout_hit = (state_q != ST_IDLE) && !rx_valid && (tmo_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    sign_d      = sign_q;
    pl_mag_d    = pl_mag_q;
    pl_neg_d    = pl_neg_q;
    pr_mag_d    = pr_mag_q;
    pr_neg_d    = pr_neg_q;
    l_mag_d     = l_mag_q;
    l_neg_d     = l_neg_q;
    r_mag_d     = r_mag_q;
    r_neg_d     = r_neg_q;
    cmd_valid_d = 1'b0;
    frame_err_d = 1'b0;
    abort       = 1'b0;
    if (rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_data == ASC_LBRACE) begin
            state_d = ST_HDR;
            idx_d   = 4'd0;
          end
        end
        ST_HDR: begin
          if (rx_data != hdr_byte(idx_q)) abort = 1'b1;
          else if (idx_q == HDR_LAST) begin
            state_d = ST_LNUM;
            idx_d   = 4'd0;
          end else idx_d = idx_q + 4'd1;
        end
        ST_MID: begin
          if (rx_data != mid_byte(idx_q)) abort = 1'b1;
          else if (idx_q == MID_LAST) begin
            state_d = ST_RNUM;
            idx_d   = 4'd0;
          end else idx_d = idx_q + 4'd1;
        end
        ST_LNUM, ST_RNUM: begin
          case (idx_q)
            4'd0: begin
              if (rx_data == ASC_MINUS) begin
                sign_d = 1'b1;
                idx_d  = 4'd1;
              end else if (rx_data == ASC_ZERO) begin
                sign_d = 1'b0;
                idx_d  = 4'd2;
              end else abort = 1'b1;
            end
            4'd1: begin
              if (rx_data == ASC_ZERO) idx_d = 4'd2;
              else abort = 1'b1;
            end
            4'd2: begin
              if (rx_data == ASC_DOT) idx_d = 4'd3;
              else abort = 1'b1;
            end
            default: begin
              // Low nibble of an ASCII digit is its value; -0 keeps neg clear.
              if (!is_digit) abort = 1'b1;
              else if (state_q == ST_LNUM) begin
                pl_mag_d = rx_data[3:0];
                pl_neg_d = sign_q && (rx_data != ASC_ZERO);
                state_d  = ST_MID;
                idx_d    = 4'd0;
              end else begin
                pr_mag_d = rx_data[3:0];
                pr_neg_d = sign_q && (rx_data != ASC_ZERO);
                state_d  = ST_TAIL;
                idx_d    = 4'd0;
              end
            end
          endcase
        end
        ST_TAIL: begin
          if (idx_q == 4'd0) begin
            if (rx_data == ASC_RBRACE) idx_d = 4'd1;
            else abort = 1'b1;
          end else if (rx_data == ASC_LF) begin
            l_mag_d     = pl_mag_q;
            l_neg_d     = pl_neg_q;
            r_mag_d     = pr_mag_q;
            r_neg_d     = pr_neg_q;
            cmd_valid_d = 1'b1;
            state_d     = ST_IDLE;
            idx_d       = 4'd0;
          end else abort = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = 4'd0;
        end
      endcase
      if (abort) begin
        frame_err_d = 1'b1;
        idx_d       = 4'd0;
        state_d     = (rx_data == ASC_LBRACE) ? ST_HDR : ST_IDLE;
      end
    end else if (timeout_hit) begin
      frame_err_d = 1'b1;
      state_d     = ST_IDLE;
      idx_d       = 4'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= 4'd0;
      sign_q      <= 1'b0;
      pl_mag_q    <= 4'd0;
      pl_neg_q    <= 1'b0;
      pr_mag_q    <= 4'd0;
      pr_neg_q    <= 1'b0;
      l_mag_q     <= 4'd0;
      l_neg_q     <= 1'b0;
      r_mag_q     <= 4'd0;
      r_neg_q     <= 1'b0;
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sign_q      <= sign_d;
      pl_mag_q    <= pl_mag_d;
      pl_neg_q    <= pl_neg_d;
      pr_mag_q    <= pr_mag_d;
      pr_neg_q    <= pr_neg_d;
      l_mag_q     <= l_mag_d;
      l_neg_q     <= l_neg_d;
      r_mag_q     <= r_mag_d;
      r_neg_q     <= r_neg_d;
      cmd_valid_q <= cmd_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  cmd_decode u_cmd_decode (
    .l_mag_i    (l_mag_q),
    .l_neg_i    (l_neg_q),
    .r_mag_i    (r_mag_q),
    .r_neg_i    (r_neg_q),
    .move_cmd_o (move_cmd)
  );

  assign left_speed  = l_mag_q;
  assign right_speed = r_mag_q;
  assign left_neg    = l_neg_q;
  assign right_neg   = r_neg_q;
  assign speed_level = (l_mag_q > r_mag_q) ? l_mag_q : r_mag_q;
  assign cmd_valid   = cmd_valid_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_json_cmd_rx.sv
// Self-checking bench for json_cmd_rx: string-level frame model plus directed literal checks.
module tb_json_cmd_rx;

  localparam int TMO = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [3:0] left_speed, right_speed, move_cmd, speed_level;
  logic       left_neg, right_neg, cmd_valid, frame_err;

  int checks = 0;
  int failures = 0;

  json_cmd_rx #(.TIMEOUT_CLKS(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .left_speed  (left_speed),
    .right_speed (right_speed),
    .left_neg    (left_neg),
    .right_neg   (right_neg),
    .move_cmd    (move_cmd),
    .speed_level (speed_level),
    .cmd_valid   (cmd_valid),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: every legal frame as a string ----------------
  string vf[$];
  int    vf_l[$];
  int    vf_r[$];

  function automatic string num_str(input int s, input int d);
    return (s != 0) ? $sformatf("-0.%0d", d) : $sformatf("0.%0d", d);
  endfunction

  function automatic void build_frames();
    for (int ls = 0; ls < 2; ls++)
      for (int ld = 0; ld < 10; ld++)
        for (int rs = 0; rs < 2; rs++)
          for (int rd = 0; rd < 10; rd++) begin
            vf.push_back({"{\"T\":1,\"L\":", num_str(ls, ld), ",\"R\":", num_str(rs, rd), "}\n"});
            vf_l.push_back((ls != 0) ? -ld : ld);
            vf_r.push_back((rs != 0) ? -rd : rd);
          end
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [3:0] exp_move(input int l, input int r);
    if (l == 0 && r == 0) return 4'b1000;
    if (l > 0 && r > 0 && l == r) return 4'd0;
    if (l == 0 && r > 0) return 4'd1;
    if (l > 0 && r == 0) return 4'd2;
    if (l < 0 && r < 0 && l == r) return 4'd3;
    if (l < 0 && r > 0 && -l == r) return 4'd4;
    if (l > 0 && r < 0 && l == -r) return 4'd5;
    if (l == 0 && r < 0) return 4'd6;
    if (l < 0 && r == 0) return 4'd7;
    return 4'b1111;
  endfunction

  string fbuf = "";
  bit    in_frame = 1'b0;
  int    stall = 0;
  int    m_l = 0;
  int    m_r = 0;
  bit    e_cv = 1'b0;
  bit    e_fe = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      in_frame = 1'b0; fbuf = ""; stall = 0;
      m_l = 0; m_r = 0; e_cv = 1'b0; e_fe = 1'b0;
    end else begin
      e_cv = 1'b0;
      e_fe = 1'b0;
      if (rx_valid) begin
        stall = 0;
        if (!in_frame) begin
          if (rx_data == 8'h7B) begin in_frame = 1'b1; fbuf = "{"; end
        end else begin
          string nb;
          int    full;
          bit    pre;
          nb = {fbuf, "?"};
          nb.putc(nb.len() - 1, rx_data);
          full = -1;
          pre  = 1'b0;
          foreach (vf[i]) begin
            if (vf[i] == nb) full = i;
            else if (vf[i].substr(0, nb.len() - 1) == nb) pre = 1'b1;
          end
          if (full >= 0) begin
            m_l = vf_l[full]; m_r = vf_r[full];
            e_cv = 1'b1; in_frame = 1'b0;
          end else if (pre) begin
            fbuf = nb;
          end else begin
            e_fe = 1'b1;
            if (rx_data == 8'h7B) fbuf = "{";
            else in_frame = 1'b0;
          end
        end
      end
`ifdef CMD_TIMEOUT_EN
      else if (in_frame) begin
        stall++;
        if (stall >= TMO) begin e_fe = 1'b1; in_frame = 1'b0; stall = 0; end
      end
`endif
    end
  end

  always @(negedge clk) begin
    chk("cmd_valid",   cmd_valid,   e_cv);
    chk("frame_err",   frame_err,   e_fe);
    chk("left_speed",  left_speed,  iabs(m_l));
    chk("left_neg",    left_neg,    m_l < 0);
    chk("right_speed", right_speed, iabs(m_r));
    chk("right_neg",   right_neg,   m_r < 0);
    chk("move_cmd",    move_cmd,    exp_move(m_l, m_r));
    chk("speed_level", speed_level, (iabs(m_l) > iabs(m_r)) ? iabs(m_l) : iabs(m_r));
    chk("pulse_excl",  cmd_valid & frame_err, 1'b0);
  end

  // ---------------- stimulus ----------------
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i]);
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    build_frames();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_move",  move_cmd,    4'b1000);
    chk("rst_level", speed_level, 4'd0);
    chk("rst_lspd",  left_speed,  4'd0);
    chk("rst_cv",    cmd_valid,   1'b0);
    idle(2);

    send_str("{\"T\":1,\"L\":0.5,\"R\":0.5}\n", 0);
    chk("f1_cv",    cmd_valid,   1'b1);
    chk("f1_l",     left_speed,  4'd5);
    chk("f1_r",     right_speed, 4'd5);
    chk("f1_move",  move_cmd,    4'd0);
    chk("f1_level", speed_level, 4'd5);
    idle(1);

    send_str("{\"T\":1,\"L\":-0.3,\"R\":0.3}\n", 2);
    chk("f2_lneg", left_neg, 1'b1);
    chk("f2_move", move_cmd, 4'd4);
    send_str("{\"T\":1,\"L\":-0.7,\"R\":0.0}\n", 1);
    chk("f3_move",  move_cmd,    4'd7);
    chk("f3_level", speed_level, 4'd7);
    chk("f3_rneg",  right_neg,   1'b0);

    send_str("{\"T\":", 0);
    send_byte("2");
    chk("t2_err",  frame_err, 1'b1);
    chk("t2_hold", move_cmd,  4'd7);
    send_str("{\"T\":1,\"L\":0.4,\"R\":-0.4}\n", 0);
    chk("f4_cv",   cmd_valid, 1'b1);
    chk("f4_move", move_cmd,  4'd5);

    send_str("{\"T\":1,\"L\":0.", 0);
    send_byte("{");
    chk("resync_err", frame_err, 1'b1);
    send_str("\"T\":1,\"L\":0.2,\"R\":0.0}\n", 0);
    chk("f5_cv",    cmd_valid,   1'b1);
    chk("f5_move",  move_cmd,    4'd2);
    chk("f5_level", speed_level, 4'd2);

    send_str("{\"T\":1,\"L\":-0.0,\"R\":0.0}\n", 0);
    chk("negz_lneg", left_neg, 1'b0);
    chk("negz_move", move_cmd, 4'b1000);
    send_str("{\"T\":1,\"L\":-0.0,\"R\":-0.6}\n", 0);
    chk("f6_move", move_cmd, 4'd6);
    send_str("{\"T\":1,\"L\":0.3,\"R\":0.5}\n", 0);
    chk("f7_move",  move_cmd,    4'b1111);
    chk("f7_level", speed_level, 4'd5);
    send_str("{\"T\":1,\"L\":0.0,\"R\":0.9}\n", 0);
    chk("f8_move", move_cmd, 4'd1);

    send_str("xyz}\n", 0);
    send_str("{\"T\":1,\"L\":0.a", 0);
    send_str("{\"T\":1,\"L\":0.1,\"R\":0.1}x", 0);
    chk("tail_err",  frame_err, 1'b1);
    chk("tail_hold", move_cmd,  4'd1);

`ifdef CMD_TIMEOUT_EN
    send_str("{\"T\"", 0);
    idle(TMO - 1);
    chk("tmo_early", frame_err, 1'b0);
    idle(1);
    chk("tmo_err", frame_err, 1'b1);
    send_str("{\"T\":1,\"L\":-0.8,\"R\":-0.8}\n", 0);
    chk("tmo_cv",   cmd_valid, 1'b1);
    chk("tmo_move", move_cmd,  4'd3);
`else
    send_str("{\"T\"", 0);
    idle(2 * TMO);
    send_str(":1,\"L\":-0.8,\"R\":-0.8}\n", 0);
    chk("stall_cv",   cmd_valid, 1'b1);
    chk("stall_move", move_cmd,  4'd3);
`endif

    send_str("{\"T\":1,\"L\":-0.9", 0);
    rst = 1'b1;
    #1;
    chk("mrst_err",   frame_err,   1'b0);
    chk("mrst_move",  move_cmd,    4'b1000);
    chk("mrst_level", speed_level, 4'd0);
    chk("mrst_lneg",  left_neg,    1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    idle(1);
    send_str(",\"R\":0.9}\n", 0);
    chk("mrst_nocv", cmd_valid, 1'b0);
    send_str("{\"T\":1,\"L\":-0.1,\"R\":-0.1}\n", 0);
    chk("post_cv",   cmd_valid, 1'b1);
    chk("post_move", move_cmd,  4'd3);

    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
